solver_controller: RTL

//  Host-side sequencer for the 9x9 constraint-propagation solver array.
//  - Stages a puzzle from cell-by-cell host writes into a one-hot initial_vals buffer.
//  - On go: pulses the array reset, pulses start, then watches final_vals/fail.
//  - Reports SOLVED, FAIL or STUCK with cycle and filled-cell counts.

---
 rtl/solver_controller.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/solver_controller.sv
// solver_controller: host-side sequencer for the 9x9 constraint-propagation
// solver array. Stages a puzzle from host cell writes, resets and starts the
// array on go, then watches the array's outputs until it solves, fails or
// stops making progress.
module solver_controller #(
    parameter int WIDTH        = 9,
    parameter int N            = 3,
    parameter int STALL_CYCLES = 4,
    parameter int MAX_CYCLES   = 1023,
    parameter int CNT_W        = 16
) (
    input  logic                           clock,
    input  logic                           reset_L,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [3:0]                     wr_row,
    input  logic [3:0]                     wr_col,
    input  logic [3:0]                     wr_digit,
    input  logic                           clear,
    input  logic                           go,
    input  logic [WIDTH*WIDTH*WIDTH-1:0]   final_vals,
    input  logic                           fail_in,
    output logic [WIDTH*WIDTH*WIDTH-1:0]   initial_vals,
    output logic                           start,
    output logic                           array_rst_L,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [CNT_W-1:0]               cycles,
    output logic [6:0]                     filled
);

    // Cell count of the grid; cell (r,c) occupies one-hot slot r*WIDTH+c.
    localparam int CELLS   = N * N * N * N;
    localparam int IDX_W   = $clog2(CELLS);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_SOLVED = 2'd1;
    localparam logic [1:0] ST_FAIL   = 2'd2;
    localparam logic [1:0] ST_STUCK  = 2'd3;

    logic [2:0]                  state;
    logic [2:0]                  state_next;
    logic [1:0]                  status_next;
    logic                        run_exit;
    logic                        idle_like;
    logic                        transfer;
    logic                        in_range;
    logic [IDX_W-1:0]            cell_idx;
    logic [WIDTH-1:0]            digit_onehot;
    logic [6:0]                  filled_next;
    logic [STALL_W-1:0]          stall;
    logic [CELLS-1:0][WIDTH-1:0] stage_q;

    // DONE accepts host traffic exactly like IDLE; clear blocks writes so it always wins.
    assign idle_like    = (state == S_IDLE) || (state == S_DONE);
    assign wr_ready     = idle_like && !clear;
    assign transfer     = wr_valid && wr_ready;
    assign in_range     = (wr_row < 4'(WIDTH)) && (wr_col < 4'(WIDTH));
    assign cell_idx     = IDX_W'(wr_row) * IDX_W'(WIDTH) + IDX_W'(wr_col);
    assign initial_vals = stage_q;
    assign start        = (state == S_START);
    assign busy         = (state == S_CLR) || (state == S_START) || (state == S_RUN);
    assign done         = (state == S_DONE);

    // Translate the host digit into the array's one-hot cell encoding; 0 and >WIDTH mean empty.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        digit_onehot = '0;
        if (wr_digit != 4'd0 && wr_digit <= 4'(WIDTH))
            digit_onehot = WIDTH'(1) << (wr_digit - 4'd1);
    end

    // Count cells the array has resolved to any value.
    always_comb begin
        filled_next = '0;
        for (int i = 0; i < CELLS; i++)
            filled_next = filled_next + {6'd0, |final_vals[i*WIDTH +: WIDTH]};
    end

    // Sequencer transitions; RUN exits are judged on the registered progress counters.
    always_comb begin
        state_next  = state;
        status_next = status;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_next  = S_CLR;
                    status_next = ST_NONE;
                end
            end
            S_CLR:   state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN: begin
                if (fail_in) begin
                    state_next  = S_DONE;
                    status_next = ST_FAIL;
                end else if (filled == 7'(CELLS)) begin
                    state_next  = S_DONE;
                    status_next = ST_SOLVED;
                end else if (stall == STALL_W'(STALL_CYCLES) ||
                             cycles == CNT_W'(MAX_CYCLES)) begin
                    state_next  = S_DONE;
                    status_next = ST_STUCK;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign run_exit = (state == S_RUN) && (state_next == S_DONE);

    // FSM, verdict and the array reset; array_rst_L is low only while in CLR.
    always_ff @(posedge clock or negedge reset_L) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_L) begin
            state       <= S_IDLE;
            status      <= ST_NONE;
            array_rst_L <= 1'b0;
        end else begin
            state       <= state_next;
            status      <= status_next;
            array_rst_L <= (state_next != S_CLR);
        end
    end

    // Progress counters: zeroed at START, advanced each RUN cycle, frozen on the exit cycle.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            cycles <= '0;
            filled <= '0;
            stall  <= '0;
        end else if (state == S_START) begin
            cycles <= '0;
            filled <= '0;
            stall  <= '0;
        end else if (state == S_RUN && !run_exit) begin
            if (cycles != {CNT_W{1'b1}})
                cycles <= cycles + CNT_W'(1);
            filled <= filled_next;
            if (filled_next == filled)
                stall <= stall + STALL_W'(1);
            else
                stall <= '0;
        end
    end

    // Staging buffer: one-cycle clear, single-cell writes, ignored while a solve is in flight.
    always_ff @(posedge clock or negedge reset_L) begin
        // NOTE: the buffer is flops rather than RAM because it must reset and clear in a single cycle.
        if (!reset_L) begin
            stage_q <= '0;
        end else if (idle_like && clear) begin
            stage_q <= '0;
        end else if (transfer && in_range) begin
            stage_q[cell_idx] <= digit_onehot;
        end
    end

endmodule
